nn_bus_arbiter: RTL and testbench

Shares the single register/weight access port of the trainable neural-network core between two requesters: the management SoC over Wishbone and the logic-analyzer (LA) debug path. It sits between the user-project Wishbone/LA pins and the core's internal bus. It decodes the Wishbone address window, grants one requester at a time with round-robin on ties, and sequences a request/ack handshake to the core. A watchdog ensures a stuck core never hangs either requester.

---
 rtl/nn_bus_pkg.sv | 32 +++
 rtl/nn_bus_watchdog.sv | 38 +++
 rtl/nn_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_nn_bus_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_bus_pkg.sv
// Shared types and constants for the neural-network core bus arbiter.
package nn_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_XFER = 2'd1,
    LA_XFER = 2'd2
  } state_e;

  localparam int              WDOG_W       = 10;
  localparam logic [9:0]      WDOG_ONE     = 10'd1;
  localparam logic [9:0]      WDOG_ZERO    = 10'd0;
  localparam logic [31:0]     TIMEOUT_DATA = 32'hFFFF_FFFF;
  localparam logic [3:0]      LA_BE        = 4'hF;

  // On a tie the requester that did not win the previous tie is chosen.
  function automatic state_e pick_grant(input logic wb_elig, input logic la_elig,
                                        input logic last_la);
    state_e g;
    if (wb_elig && la_elig) begin
      g = last_la ? WB_XFER : LA_XFER;
    end else if (wb_elig) begin
      g = WB_XFER;
    end else if (la_elig) begin
      g = LA_XFER;
    end else begin
      g = IDLE;
    end
    return g;
  endfunction

endpackage

// File: rtl/nn_bus_watchdog.sv
// Saturating transfer-length counter; flags expiry when the count reaches the limit.
module nn_bus_watchdog
  import nn_bus_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [WDOG_W-1:0] limit_i,
  output logic              expired_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // Next count: clear outside a transfer, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = WDOG_ZERO;
    end else if (enable_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + WDOG_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= WDOG_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && !clear_i && (cnt_q == limit_i);

endmodule

// File: rtl/nn_bus_arbiter.sv
// Arbitrates the core register/weight port between Wishbone and the LA debug path,
// with a watchdog so a silent core still completes every transfer.
module nn_bus_arbiter
  import nn_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 12,
  parameter int          TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_adr_i,
  input  logic [31:0]       la_dat_i,
  output logic              la_ack_o,
  output logic [31:0]       la_dat_o,
  output logic              core_req_o,
  output logic              core_we_o,
  output logic [3:0]        core_be_o,
  output logic [ADDR_W-1:0] core_adr_o,
  output logic [31:0]       core_dat_o,
  input  logic [31:0]       core_dat_i,
  input  logic              core_ack_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

  state_e            state_q;
  logic              last_la_q;
  logic              abort_q;
  logic              wbs_ack_q, la_ack_q, timeout_q, busy_q;
  logic [31:0]       wbs_dat_q, la_dat_q;
  logic              core_req_q, core_we_q;
  logic [3:0]        core_be_q;
  logic [ADDR_W-1:0] core_adr_q;
  logic [31:0]       core_dat_q;

  logic              wb_req_s, wb_in_win_s, wb_hit_s, wb_miss_s;
  logic              wb_elig_s, la_elig_s, tie_s;
  logic              in_xfer_s, done_s, wdog_expired_s;
  logic [31:0]       done_dat_s;
  state_e            grant_s;
  logic              unused_s;

  assign wb_req_s    = wbs_cyc_i & wbs_stb_i;
  assign wb_in_win_s = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign wb_hit_s    = wb_req_s & wb_in_win_s;
  assign wb_miss_s   = wb_req_s & ~wb_in_win_s;

  // A requester whose ack is showing this cycle is still holding its strobe from the last access.
  assign wb_elig_s   = wb_hit_s & ~wbs_ack_q;
  assign la_elig_s   = la_req_i & ~la_ack_q;
  assign tie_s       = wb_elig_s & la_elig_s;
  assign grant_s     = pick_grant(wb_elig_s, la_elig_s, last_la_q);

  assign in_xfer_s   = (state_q == WB_XFER) || (state_q == LA_XFER);
  assign done_s      = in_xfer_s && (core_ack_i || wdog_expired_s);
  assign done_dat_s  = core_ack_i ? core_dat_i : TIMEOUT_DATA;
  assign unused_s    = ^wbs_adr_i[1:0];

  nn_bus_watchdog u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clear_i   (~in_xfer_s),
    .enable_i  (in_xfer_s),
    .limit_i   (LIMIT),
    .expired_o (wdog_expired_s)
  );

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      last_la_q  <= 1'b1;
      abort_q    <= 1'b0;
      wbs_ack_q  <= 1'b0;
      wbs_dat_q  <= 32'h0000_0000;
      la_ack_q   <= 1'b0;
      la_dat_q   <= 32'h0000_0000;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      core_req_q <= 1'b0;
      core_we_q  <= 1'b0;
      core_be_q  <= 4'h0;
      core_adr_q <= {ADDR_W{1'b0}};
      core_dat_q <= 32'h0000_0000;
    end else begin
      wbs_ack_q <= 1'b0;
      la_ack_q  <= 1'b0;
      timeout_q <= 1'b0;

      // Out-of-window accesses are answered locally and never reach the core.
      if (wb_miss_s && (state_q != WB_XFER) && !wbs_ack_q) begin
        wbs_ack_q <= 1'b1;
        wbs_dat_q <= 32'h0000_0000;
      end

      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (grant_s == WB_XFER) begin
            state_q    <= WB_XFER;
            busy_q     <= 1'b1;
            core_req_q <= 1'b1;
            core_we_q  <= wbs_we_i;
            core_be_q  <= wbs_sel_i;
            core_adr_q <= wbs_adr_i[ADDR_W+1:2];
            core_dat_q <= wbs_dat_i;
            if (tie_s) begin
              last_la_q <= 1'b0;
            end
          end else if (grant_s == LA_XFER) begin
            state_q    <= LA_XFER;
            busy_q     <= 1'b1;
            core_req_q <= 1'b1;
            core_we_q  <= la_we_i;
            core_be_q  <= LA_BE;
            core_adr_q <= la_adr_i;
            core_dat_q <= la_dat_i;
            if (tie_s) begin
              last_la_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end

        WB_XFER, LA_XFER: begin
          if ((state_q == WB_XFER) && !wbs_cyc_i) begin
            abort_q <= 1'b1;
          end
          if (done_s) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            core_req_q <= 1'b0;
            timeout_q  <= ~core_ack_i;
            if (state_q == LA_XFER) begin
              la_ack_q <= 1'b1;
              la_dat_q <= done_dat_s;
            end else if (!abort_q && wbs_cyc_i) begin
              wbs_ack_q <= 1'b1;
              wbs_dat_q <= done_dat_s;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          core_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign wbs_ack_o  = wbs_ack_q;
  assign wbs_dat_o  = wbs_dat_q;
  assign la_ack_o   = la_ack_q;
  assign la_dat_o   = la_dat_q;
  assign core_req_o = core_req_q;
  assign core_we_o  = core_we_q;
  assign core_be_o  = core_be_q;
  assign core_adr_o = core_adr_q;
  assign core_dat_o = core_dat_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_nn_bus_arbiter.sv
// Directed bench for nn_bus_arbiter: scripted core responder plus an ack scoreboard.
module tb_nn_bus_arbiter;

  localparam int ADDR_W = 12;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              la_req_i, la_we_i;
  logic [ADDR_W-1:0] la_adr_i;
  logic [31:0]       la_dat_i;
  logic              la_ack_o;
  logic [31:0]       la_dat_o;
  logic              core_req_o, core_we_o;
  logic [3:0]        core_be_o;
  logic [ADDR_W-1:0] core_adr_o;
  logic [31:0]       core_dat_o;
  logic [31:0]       core_dat_i;
  logic              core_ack_i;
  logic              busy_o, timeout_o;

  typedef struct {
    bit          is_la;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          core_delay = 1;
  int          req_cycles = 0;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_dat = 32'h0000_0000;

  always #5 wb_clk_i = ~wb_clk_i;

  nn_bus_arbiter #(
    .BASE_ADDR (32'h3000_0000),
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (8)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .la_req_i   (la_req_i),
    .la_we_i    (la_we_i),
    .la_adr_i   (la_adr_i),
    .la_dat_i   (la_dat_i),
    .la_ack_o   (la_ack_o),
    .la_dat_o   (la_dat_o),
    .core_req_o (core_req_o),
    .core_we_o  (core_we_o),
    .core_be_o  (core_be_o),
    .core_adr_o (core_adr_o),
    .core_dat_o (core_dat_o),
    .core_dat_i (core_dat_i),
    .core_ack_i (core_ack_i),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Caller is already in cycle 1 of the transfer; returns the cycle in which the ack is seen.
  task automatic wait_ack(input bit la, input int limit, output int n);
    n = 1;
    while (((la ? la_ack_o : wbs_ack_o) !== 1'b1) && (n < limit)) begin
      tick();
      n++;
    end
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
  endtask

  task automatic wb_idle();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic la_start(input logic we, input logic [ADDR_W-1:0] adr, input logic [31:0] dat);
    la_req_i = 1'b1;
    la_we_i  = we;
    la_adr_i = adr;
    la_dat_i = dat;
  endtask

  // Core model: acks core_delay cycles into a request; read data encodes the word address.
  initial begin
    core_ack_i = 1'b0;
    core_dat_i = 32'h0000_0000;
    forever begin
      @(posedge wb_clk_i);
      #1;
      core_ack_i = 1'b0;
      if (core_req_o === 1'b1) begin
        req_cycles++;
        if (req_cycles == core_delay) begin
          core_ack_i = 1'b1;
          core_dat_i = fixed_en ? fixed_dat : {20'hDA7A0, core_adr_o};
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Scoreboard: every ack pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk_i);
      if (wbs_ack_o === 1'b1) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_wb_unexpected: observed wbs_ack with data %h, expected no ack", wbs_dat_o);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_wb_source", {31'd0, e.is_la}, 32'd0);
          check("sb_wb_dat", wbs_dat_o, e.dat);
        end
      end
      if (la_ack_o === 1'b1) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_la_unexpected: observed la_ack with data %h, expected no ack", la_dat_o);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_la_source", {31'd0, e.is_la}, 32'd1);
          check("sb_la_dat", la_dat_o, e.dat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    wb_rst_i  = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0000_0000;
    wbs_dat_i = 32'h0000_0000;
    la_req_i  = 1'b0;
    la_we_i   = 1'b0;
    la_adr_i  = 12'd0;
    la_dat_i  = 32'h0000_0000;
    tick();
    tick();
    check("rst_wbs_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_la_ack", {31'd0, la_ack_o}, 32'd0);
    check("rst_core_req", {31'd0, core_req_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    check("rst_wbs_dat", wbs_dat_o, 32'h0000_0000);
    check("rst_la_dat", la_dat_o, 32'h0000_0000);
    check("rst_core_adr", {20'd0, core_adr_o}, 32'd0);
    wb_rst_i = 1'b0;
    tick();

    // Wishbone write, core acks in cycle 1.
    core_delay = 1;
    wb_start(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'b0011);
    sb.push_back('{is_la: 1'b0, dat: 32'hDA7A_0004});
    tick();
    check("wr_core_req", {31'd0, core_req_o}, 32'd1);
    check("wr_core_adr", {20'd0, core_adr_o}, 32'd4);
    check("wr_core_be", {28'd0, core_be_o}, 32'h3);
    check("wr_core_we", {31'd0, core_we_o}, 32'd1);
    check("wr_core_dat", core_dat_o, 32'hA5A5_0001);
    check("wr_busy", {31'd0, busy_o}, 32'd1);
    check("wr_ack_c1", {31'd0, wbs_ack_o}, 32'd0);
    tick();
    check("wr_ack_c2", {31'd0, wbs_ack_o}, 32'd1);
    check("wr_req_drop", {31'd0, core_req_o}, 32'd0);
    wb_idle();
    tick();
    check("wr_ack_c3", {31'd0, wbs_ack_o}, 32'd0);

    // LA read, core answers after 5 cycles.
    core_delay = 5;
    fixed_en   = 1'b1;
    fixed_dat  = 32'h1234_5678;
    la_start(1'b0, 12'd7, 32'h0000_0000);
    sb.push_back('{is_la: 1'b1, dat: 32'h1234_5678});
    tick();
    check("la_core_be", {28'd0, core_be_o}, 32'hF);
    check("la_core_adr", {20'd0, core_adr_o}, 32'd7);
    check("la_core_we", {31'd0, core_we_o}, 32'd0);
    wait_ack(1'b1, 40, n);
    check("la_latency", n, 32'd6);
    la_req_i = 1'b0;
    tick();
    check("la_ack_pulse", {31'd0, la_ack_o}, 32'd0);
    check("la_dat_hold", la_dat_o, 32'h1234_5678);
    fixed_en = 1'b0;

    // First tie after reset goes to Wishbone, LA follows.
    core_delay = 2;
    wb_start(1'b0, 32'h3000_0020, 32'h0000_0000, 4'hF);
    la_start(1'b0, 12'd3, 32'h0000_0000);
    sb.push_back('{is_la: 1'b0, dat: 32'hDA7A_0008});
    sb.push_back('{is_la: 1'b1, dat: 32'hDA7A_0003});
    tick();
    check("tie1_wb_first", {20'd0, core_adr_o}, 32'd8);
    wait_ack(1'b0, 40, n);
    check("tie1_wb_latency", n, 32'd3);
    wb_idle();
    tick();
    check("tie1_la_second", {20'd0, core_adr_o}, 32'd3);
    check("tie1_la_req", {31'd0, core_req_o}, 32'd1);
    wait_ack(1'b1, 40, n);
    check("tie1_la_latency", n, 32'd3);
    la_req_i = 1'b0;
    tick();
    tick();

    // Repeated tie goes to LA.
    wb_start(1'b0, 32'h3000_0030, 32'h0000_0000, 4'hF);
    la_start(1'b0, 12'd9, 32'h0000_0000);
    sb.push_back('{is_la: 1'b1, dat: 32'hDA7A_0009});
    sb.push_back('{is_la: 1'b0, dat: 32'hDA7A_000C});
    tick();
    check("tie2_la_first", {20'd0, core_adr_o}, 32'd9);
    wait_ack(1'b1, 40, n);
    la_req_i = 1'b0;
    tick();
    check("tie2_wb_second", {20'd0, core_adr_o}, 32'hC);
    wait_ack(1'b0, 40, n);
    check("tie2_wb_ack", {31'd0, wbs_ack_o}, 32'd1);
    wb_idle();
    tick();

    // Core never acks: watchdog completes the read.
    core_delay = -1;
    wb_start(1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF);
    sb.push_back('{is_la: 1'b0, dat: 32'hFFFF_FFFF});
    tick();
    check("to_core_req", {31'd0, core_req_o}, 32'd1);
    wait_ack(1'b0, 40, n);
    check("to_latency", n, 32'd10);
    check("to_pulse", {31'd0, timeout_o}, 32'd1);
    check("to_dat", wbs_dat_o, 32'hFFFF_FFFF);
    wb_idle();
    tick();
    check("to_pulse_end", {31'd0, timeout_o}, 32'd0);
    check("to_ack_end", {31'd0, wbs_ack_o}, 32'd0);

    // Out-of-window access.
    wb_start(1'b0, 32'h2000_0000, 32'h0000_0000, 4'hF);
    sb.push_back('{is_la: 1'b0, dat: 32'h0000_0000});
    tick();
    check("miss_ack", {31'd0, wbs_ack_o}, 32'd1);
    check("miss_dat", wbs_dat_o, 32'h0000_0000);
    check("miss_core_req", {31'd0, core_req_o}, 32'd0);
    check("miss_busy", {31'd0, busy_o}, 32'd0);
    wb_idle();
    tick();
    check("miss_ack_end", {31'd0, wbs_ack_o}, 32'd0);

    // Reset in the middle of an LA transfer.
    la_start(1'b0, 12'd5, 32'h0000_0000);
    tick();
    check("mid_busy", {31'd0, busy_o}, 32'd1);
    tick();
    tick();
    wb_rst_i = 1'b1;
    tick();
    check("mid_rst_core_req", {31'd0, core_req_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_la_ack", {31'd0, la_ack_o}, 32'd0);
    check("mid_rst_la_dat", la_dat_o, 32'h0000_0000);
    wb_rst_i = 1'b0;
    la_req_i = 1'b0;
    tick();
    tick();
    check("post_rst_la_ack", {31'd0, la_ack_o}, 32'd0);

    core_delay = 1;
    wb_start(1'b0, 32'h3000_0040, 32'h0000_0000, 4'hF);
    la_start(1'b0, 12'd2, 32'h0000_0000);
    sb.push_back('{is_la: 1'b0, dat: 32'hDA7A_0010});
    sb.push_back('{is_la: 1'b1, dat: 32'hDA7A_0002});
    tick();
    check("rst_tie_wb", {20'd0, core_adr_o}, 32'h10);
    wait_ack(1'b0, 40, n);
    wb_idle();
    tick();
    check("rst_tie_la", {20'd0, core_adr_o}, 32'd2);
    wait_ack(1'b1, 40, n);
    check("rst_tie_la_ack", {31'd0, la_ack_o}, 32'd1);
    la_req_i = 1'b0;
    tick();
    tick();

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
